// File: rtl/cp0_exc_sequencer.sv
// cp0_exc_sequencer
//   Sequences the CP0 register writes for exception entry and ERET. It takes
//   over the single CP0 write port and stalls the pipeline while it writes
//   EPC, BADVADDR, CAUSE and STATUS one per cycle. It then issues a one-cycle
//   flush with the redirect PC.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid_i, pc_i     MEM-stage instruction valid / PC
//   in_delay_slot_i   instruction sits in a branch delay slot
//   badvaddr_i        faulting data address
//   exc_flags_i       {eret, ades, adel_data, break, syscall, ov, ri, adel_fetch}
//   status_i/cause_i/epc_i   current CP0 values
//   pipe_we_i/pipe_waddr_i/pipe_wdata_i   same-cycle MTC0 write (forwarded)
//   we_o/waddr_o/wdata_o/exc_o            CP0 write port
//   stall_o, flush_o, new_pc_o            pipeline control
module cp0_exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delay_slot_i,
  input  logic [31:0] badvaddr_i,
  input  logic [7:0]  exc_flags_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        exc_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  typedef enum logic [2:0] {
    IDLE, WR_EPC, WR_BADV, WR_CAUSE, WR_STATUS, REDIRECT
  } state_t;

  state_t state, state_nxt;

  // CP0 values as seen by this instruction, including a same-cycle MTC0
  logic [31:0] fwd_status, fwd_cause, fwd_epc;
  assign fwd_status = (pipe_we_i && pipe_waddr_i == CP0_REG_STATUS) ? pipe_wdata_i : status_i;
  assign fwd_cause  = (pipe_we_i && pipe_waddr_i == CP0_REG_CAUSE)  ? pipe_wdata_i : cause_i;
  assign fwd_epc    = (pipe_we_i && pipe_waddr_i == CP0_REG_EPC)    ? pipe_wdata_i : epc_i;

  // CAUSE[6:2] is replaced by the new ExcCode, so the old bits are dropped
  logic unused_cause;
  assign unused_cause = ^fwd_cause[6:2];

  logic int_pend, take;
  assign int_pend = fwd_status[0] & ~fwd_status[1] & (|(fwd_cause[15:8] & fwd_status[15:8]));
  assign take     = valid_i & (int_pend | (|exc_flags_i));

  // Priority resolution; eret only wins when nothing else is pending
  logic [4:0]  code;
  logic        adr_err, is_eret;
  logic [31:0] badv_sel;
  always_comb begin
    code     = 5'd0;
    adr_err  = 1'b0;
    is_eret  = 1'b0;
    badv_sel = badvaddr_i;
    if (int_pend)            code = 5'd0;
    else if (exc_flags_i[0]) begin code = 5'd4; adr_err = 1'b1; badv_sel = pc_i; end
    else if (exc_flags_i[1]) code = 5'd10;
    else if (exc_flags_i[2]) code = 5'd12;
    else if (exc_flags_i[3]) code = 5'd8;
    else if (exc_flags_i[4]) code = 5'd9;
    else if (exc_flags_i[5]) begin code = 5'd4; adr_err = 1'b1; end
    else if (exc_flags_i[6]) begin code = 5'd5; adr_err = 1'b1; end
    else if (exc_flags_i[7]) is_eret = 1'b1;
  end

  // Latched at detection
  logic [31:0] pc_q, badv_q, status_q, epc_q, cause_wd_q;
  logic        bd_q, adr_q, eret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
      if (state == IDLE && take) begin
        pc_q     <= pc_i;
        bd_q     <= in_delay_slot_i;
        badv_q   <= badv_sel;
        adr_q    <= adr_err;
        eret_q   <= is_eret;
        status_q <= fwd_status;
        epc_q    <= fwd_epc;
        // Nested exception (EXL already set) keeps the original BD bit
        cause_wd_q <= {(fwd_status[1] ? fwd_cause[31] : in_delay_slot_i),
                       fwd_cause[30:7], code, fwd_cause[1:0]};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    we_o      = 1'b0;
    waddr_o   = 5'd0;
    wdata_o   = 32'd0;
    exc_o     = 1'b0;
    stall_o   = 1'b0;
    flush_o   = 1'b0;
    new_pc_o  = 32'd0;
    case (state)
      IDLE: begin
        if (take) begin
          if (is_eret)             state_nxt = WR_STATUS;
          else if (!fwd_status[1]) state_nxt = WR_EPC;
          else if (adr_err)        state_nxt = WR_BADV;
          else                     state_nxt = WR_CAUSE;
        end
      end
      WR_EPC: begin
        {we_o, exc_o, stall_o} = 3'b111;
        waddr_o   = CP0_REG_EPC;
        wdata_o   = bd_q ? pc_q - 32'd4 : pc_q;
        state_nxt = adr_q ? WR_BADV : WR_CAUSE;
      end
      WR_BADV: begin
        {we_o, exc_o, stall_o} = 3'b111;
        waddr_o   = CP0_REG_BADVADDR;
        wdata_o   = badv_q;
        state_nxt = WR_CAUSE;
      end
      WR_CAUSE: begin
        {we_o, exc_o, stall_o} = 3'b111;
        waddr_o   = CP0_REG_CAUSE;
        wdata_o   = cause_wd_q;
        state_nxt = WR_STATUS;
      end
      WR_STATUS: begin
        {we_o, exc_o, stall_o} = 3'b111;
        waddr_o   = CP0_REG_STATUS;
        wdata_o   = eret_q ? (status_q & ~32'h2) : (status_q | 32'h2);
        state_nxt = REDIRECT;
      end
      REDIRECT: begin
        flush_o   = 1'b1;
        new_pc_o  = eret_q ? epc_q : EXC_VECTOR;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Testbench for cp0_exc_sequencer: directed test-plan cases followed by
// random transactions, all checked against a behavioural model that derives
// the expected write list and redirect target from the architectural rules.
module tb_cp0_exc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] pc;
  logic        in_delay_slot;
  logic [31:0] badvaddr;
  logic [7:0]  exc_flags;
  logic [31:0] status, cause, epc;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        we, exc, stall, flush;
  logic [4:0]  waddr;
  logic [31:0] wdata, new_pc;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  cp0_exc_sequencer dut (
    .clk(clk), .rst(rst), .valid_i(valid), .pc_i(pc),
    .in_delay_slot_i(in_delay_slot), .badvaddr_i(badvaddr),
    .exc_flags_i(exc_flags), .status_i(status), .cause_i(cause), .epc_i(epc),
    .pipe_we_i(pipe_we), .pipe_waddr_i(pipe_waddr), .pipe_wdata_i(pipe_wdata),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .exc_o(exc),
    .stall_o(stall), .flush_o(flush), .new_pc_o(new_pc)
  );

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    valid = 0; pc = 0; in_delay_slot = 0; badvaddr = 0; exc_flags = 0;
    status = 0; cause = 0; epc = 0; pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".ctl"}, {28'd0, we, exc, stall, flush}, 32'd0);
    check({tag, ".data"}, {waddr, wdata, new_pc} == '0, 1);
  endtask

  // Architectural model: builds the ordered list of CP0 writes and the
  // redirect target from the exception rules.
  task automatic model(input logic v, input logic [31:0] p, input logic b,
                       input logic [31:0] bv, input logic [7:0] fl,
                       input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
                       input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       output bit taken, output wr_t q[$], output logic [31:0] npc);
    int codes [7] = '{4, 10, 12, 8, 9, 4, 5};  // adel_fetch..ades, in priority order
    logic [31:0] s, c, e, cw;
    bit intr, exl;
    int sel;
    wr_t w;
    q = {};
    s = (pw && pa == 12) ? pd : st;
    c = (pw && pa == 13) ? pd : ca;
    e = (pw && pa == 14) ? pd : ep;
    exl  = s[1];
    intr = v && s[0] && !exl && ((c[15:8] & s[15:8]) != 0);
    sel = -1;
    for (int i = 0; i < 7; i++) if (sel < 0 && fl[i]) sel = i;
    taken = v && (intr || fl != 0);
    npc = 32'hBFC00380;
    if (!taken) return;
    if (!intr && sel < 0) begin            // ERET
      w.a = 12; w.d = s & ~32'h2; q.push_back(w);
      npc = e;
      return;
    end
    if (!exl) begin w.a = 14; w.d = b ? p - 4 : p; q.push_back(w); end
    if (!intr && (codes[sel] == 4 || codes[sel] == 5)) begin
      w.a = 8; w.d = (sel == 0) ? p : bv; q.push_back(w);
    end
    cw = c;
    cw[6:2] = intr ? 5'd0 : 5'(codes[sel]);
    cw[31] = exl ? c[31] : b;
    w.a = 13; w.d = cw; q.push_back(w);
    w.a = 12; w.d = s | 32'h2; q.push_back(w);
  endtask

  task automatic txn(input string tag, input logic v, input logic [31:0] p, input logic b,
                     input logic [31:0] bv, input logic [7:0] fl,
                     input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
                     input logic pw, input logic [4:0] pa, input logic [31:0] pd);
    bit taken;
    wr_t q[$];
    logic [31:0] npc;
    model(v, p, b, bv, fl, st, ca, ep, pw, pa, pd, taken, q, npc);
    @(negedge clk);
    valid = v; pc = p; in_delay_slot = b; badvaddr = bv; exc_flags = fl;
    status = st; cause = ca; epc = ep; pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    @(posedge clk); #1;
    idle_inputs();
    if (!taken) begin
      check_quiet({tag, ".notaken"});
      return;
    end
    foreach (q[i]) begin
      check($sformatf("%s.w%0d.ctl", tag, i), {28'd0, we, exc, stall, flush}, 32'hE);
      check($sformatf("%s.w%0d.addr", tag, i), {27'd0, waddr}, {27'd0, q[i].a});
      check($sformatf("%s.w%0d.data", tag, i), wdata, q[i].d);
      @(posedge clk); #1;
    end
    check({tag, ".flush.ctl"}, {28'd0, we, exc, stall, flush}, 32'h1);
    check({tag, ".flush.pc"}, new_pc, npc);
    @(posedge clk); #1;
    check_quiet({tag, ".idle"});
  endtask

  initial begin
    logic [7:0] fl;
    logic [4:0] pa;
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk); rst = 0;

    // Test plan cases
    txn("syscall", 1, 32'hBFC00100, 0, 0, 8'h08, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    txn("ov_bd",   1, 32'h80001004, 1, 0, 8'h04, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    txn("ades",    1, 32'h80000040, 0, 32'h80000003, 8'h40, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    txn("intr",    1, 32'h80000100, 0, 0, 8'h02, 32'h00000401, 32'h00000400, 32'h0, 0, 0, 0);
    txn("intr_exl",1, 32'h80000100, 0, 0, 8'h02, 32'h00000403, 32'h00000400, 32'h0, 0, 0, 0);
    txn("sys_exl", 1, 32'h80000200, 0, 0, 8'h08, 32'h00000403, 32'h80000000, 32'h0, 0, 0, 0);
    txn("eret_fwd",1, 32'h80000300, 0, 0, 8'h80, 32'h3, 32'h0, 32'h80002000, 1, 5'd12, 32'h7);
    txn("adel_f",  1, 32'h80000401, 1, 32'h12345678, 8'h01, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    txn("novalid", 0, 32'h80000500, 0, 0, 8'h08, 32'h00000401, 32'h00000400, 32'h0, 0, 0, 0);
    txn("intr_fwd",1, 32'h80000600, 0, 0, 8'h00, 32'h00000801, 32'h0, 32'h0, 1, 5'd13, 32'h00000800);

    // Reset one cycle into a syscall sequence
    @(negedge clk);
    valid = 1; pc = 32'h80000700; exc_flags = 8'h08;
    @(posedge clk); #1;
    idle_inputs();
    check("rst_mid.started", {31'd0, we}, 32'd1);
    rst = 1;
    @(posedge clk); #1;
    check_quiet("rst_mid.r0");
    rst = 0;
    repeat (4) begin
      @(posedge clk); #1;
      check_quiet("rst_mid.after");
    end

    // Random transactions
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: fl = 8'h00;
        1: fl = 8'(1 << $urandom_range(0, 7));
        default: fl = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: pa = 5'd12;
        1: pa = 5'd13;
        2: pa = 5'd14;
        default: pa = 5'($urandom);
      endcase
      txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 7) != 0), $urandom, 1'($urandom),
          $urandom, fl, $urandom, $urandom, $urandom, 1'($urandom), pa, $urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/cp0_exc_sequencer.md
Name: cp0_exc_sequencer

Overview:
- Owns the single CP0 write port during exception entry and ERET.
- Takes the committed instruction's exception flags from the MEM stage and the current STATUS/CAUSE/EPC from the CP0 register file.
- Decides whether an exception or interrupt is taken, then writes EPC, BADVADDR, CAUSE and STATUS one per cycle. While it does this it stalls the pipeline.
- Finishes with a one-cycle flush and redirect PC to the fetch stage.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for every exception and interrupt.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_i  input  1  MEM-stage instruction valid
pc_i  input  32  MEM-stage instruction PC
in_delay_slot_i  input  1  instruction is in a branch delay slot
badvaddr_i  input  32  faulting data address
exc_flags_i  input  8  {eret, ades, adel_data, break, syscall, ov, ri, adel_fetch}
status_i  input  32  CP0 STATUS
cause_i  input  32  CP0 CAUSE
epc_i  input  32  CP0 EPC
pipe_we_i  input  1  pipeline (MTC0) CP0 write enable, same cycle
pipe_waddr_i  input  5  pipeline CP0 write address
pipe_wdata_i  input  32  pipeline CP0 write data
we_o  output  1  CP0 write enable
waddr_o  output  5  CP0 write address (`CP0_REG_*)
wdata_o  output  32  CP0 write data
exc_o  output  1  write is an exception write; CP0 accepts CAUSE[31] and CAUSE[6:2] only when set
stall_o  output  1  freeze the pipeline
flush_o  output  1  flush all stages
new_pc_o  output  32  redirect PC, valid when flush_o=1

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - Reset mid-sequence aborts immediately. Writes that are not yet issued are never issued.
- Forwarding:
  - status/cause/epc used at detection are replaced by pipe_wdata_i when pipe_we_i is set and pipe_waddr_i matches STATUS/CAUSE/EPC.
- Interrupt pending:
  - STATUS[0]=1 and STATUS[1]=0 and (CAUSE[15:8] & STATUS[15:8]) != 0.
  - Only sampled when valid_i=1.
- Priority and ExcCode, highest first:
  - interrupt 0
  - adel_fetch 4
  - ri 10
  - ov 12
  - syscall 8
  - break 9
  - adel_data 4
  - ades 5
  - eret (no code)
- States: IDLE, WR_EPC, WR_BADV, WR_CAUSE, WR_STATUS, REDIRECT.
- IDLE:
  - If valid_i and (interrupt or any flag): latch pc, bd, badvaddr (pc for adel_fetch), exccode, forwarded status/cause/epc.
  - stall_o goes high from the next cycle.
  - Exception: next state is WR_EPC if latched STATUS[1]=0, else WR_BADV or WR_CAUSE.
  - ERET: next state is WR_STATUS.
- WR_EPC:
  - waddr=EPC, data = bd ? pc-4 : pc (mod 2^32).
  - Next state is WR_BADV for AdEL/AdES, else WR_CAUSE.
- WR_BADV: waddr=BADVADDR, data=latched badvaddr.
- WR_CAUSE:
  - data = {bd, cause[30:7], exccode[4:0], cause[1:0]}.
  - When EXL was already 1, bit31 keeps its old value.
- WR_STATUS:
  - Exception: data = status | 32'h2.
  - ERET: data = status & ~32'h2.
- REDIRECT:
  - we_o=0, stall_o=0, flush_o=1.
  - new_pc_o = EXC_VECTOR, or latched EPC for ERET.
  - Next state is IDLE.
- In every write state: we_o=1, exc_o=1, stall_o=1.
- Outputs are a function of the registered state and latched data only; no input-to-output combinational path.
- New requests are ignored outside IDLE; the pipeline is held by stall_o.
- In IDLE all outputs are 0.
- Latency, detection at cycle N:
  - Plain exception: writes at N+1..N+3, flush at N+4.
  - Address-error exception: flush at N+5.
  - ERET: flush at N+2.

Test Plan:
1. syscall, pc=32'hBFC00100, not delay slot, STATUS=32'h0 → EPC=BFC00100, CAUSE ExcCode=8, STATUS=32'h2 on cycles N+1..N+3. Flush at N+4 with new_pc=BFC00380.
2. ov in delay slot, pc=32'h80001004 → EPC=80001000, CAUSE[31]=1, ExcCode=12.
3. ades with badvaddr=32'h80000003 → sequence is EPC, BADVADDR=80000003, CAUSE ExcCode=5, STATUS, then flush at N+5.
4. STATUS=32'h0000_0401, cause_i[10]=1, ri flag also set → interrupt wins, ExcCode=0.
5. Same as 4 but STATUS=32'h403 (EXL=1) → no interrupt taken. With syscall under EXL=1: no EPC write, flush at N+3.
6. eret with EPC=32'h80002000, STATUS=32'h3, MTC0 of STATUS=32'h7 in the same cycle → STATUS written 32'h5 at N+1, flush at N+2 with new_pc=80002000. Reset asserted at N+1 of a separate syscall → no further writes, all outputs 0.
